// File: rtl/exe_muldiv_unit.sv
// exe_muldiv_unit: iterative multiply/divide unit for the EXE stage.
// Owns the HI/LO registers. Ops: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
// Multiply is radix-2 shift-add. Divide is radix-2 restoring.
// Each takes 33 cycles of busy.
// Optional build macro MULDIV_FAST_MUL_EN: MULT/MULTU use a single-cycle
// multiplier and skip the iteration phase. DIV/DIVU are unaffected.
//
// state  | meaning
// IDLE   | waiting for start; MTHI/MTLO are accepted here
// BUSY   | one shift-add / shift-subtract iteration per edge
// DONE   | sign fix-up, HI/LO write, done pulse
module exe_muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] readData1,
   input  logic [WIDTH-1:0] readData2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   mag_a, mag_b, a_raw;
   logic               is_div, neg_q, neg_r, div0, ovf;

   logic               accept, mt_hi, mt_lo, fast_mul;
   logic               sign_a, sign_b;
   logic [WIDTH-1:0]   abs_a, abs_b;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_step, div_step;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   div_diff, rem_nxt;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   // Request decode; anything arriving outside IDLE is dropped.
   // Sign flags are forced to 0 for the unsigned ops.
   always_comb begin
      accept = start && (state == S_IDLE) && !op[2];
      mt_hi  = start && (state == S_IDLE) && (op == 3'd4);
      mt_lo  = start && (state == S_IDLE) && (op == 3'd5);
      sign_a = !op[0] && readData1[WIDTH-1];
      sign_b = !op[0] && readData2[WIDTH-1];
      abs_a  = sign_a ? (~readData1 + 1'b1) : readData1;
      abs_b  = sign_b ? (~readData2 + 1'b1) : readData2;
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_prod;
   assign fast_mul  = accept && !op[1];
   assign fast_prod = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
`else
   assign fast_mul  = 1'b0;
`endif

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic.
   // Exit BUSY on the 32nd iteration, when the counter still reads WIDTH-1.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = fast_mul ? S_DONE : S_BUSY;
         S_BUSY:  if (cnt == CNT_W'(WIDTH-1)) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output decode: busy is purely a function of state.
   always_comb begin
      busy = (state != S_IDLE);
   end

   // One radix-2 step of each algorithm.
   // acc = {partial product, multiplier} or {remainder, dividend/quotient}.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
      mul_step  = {mul_sum, acc[WIDTH-1:1]};
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, mag_b});
      div_diff  = div_shift[WIDTH-1:0] - mag_b;
      rem_nxt   = div_ge ? div_diff : div_shift[WIDTH-1:0];
      div_step  = {rem_nxt, acc[WIDTH-2:0], div_ge};
   end

   // Sign fix-up applied on the DONE edge.
   always_comb begin
      prod_fix = neg_q ? (~acc + 1'b1) : acc;
      quo_fix  = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
      rem_fix  = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
   end

   // Operand latch on accept and iteration datapath while BUSY.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         acc    <= '0;
         mag_a  <= '0;
         mag_b  <= '0;
         a_raw  <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         div0   <= 1'b0;
         ovf    <= 1'b0;
      end else if (accept) begin
         cnt    <= '0;
         mag_a  <= abs_a;
         mag_b  <= abs_b;
         a_raw  <= readData1;
         is_div <= op[1];
         neg_q  <= sign_a ^ sign_b;
         neg_r  <= sign_a;
         div0   <= op[1] && (readData2 == '0);
         ovf    <= (op == 3'd2) && (readData1 == {1'b1, {(WIDTH-1){1'b0}}})
                   && (readData2 == '1);
`ifdef MULDIV_FAST_MUL_EN
         if (fast_mul)   acc <= fast_prod;
         else if (op[1]) acc <= {{WIDTH{1'b0}}, abs_a};
         else            acc <= {{WIDTH{1'b0}}, abs_b};
`else
         if (op[1]) acc <= {{WIDTH{1'b0}}, abs_a};
         else       acc <= {{WIDTH{1'b0}}, abs_b};
`endif
      end else if (state == S_BUSY) begin
         cnt <= cnt + 1'b1;
         acc <= is_div ? div_step : mul_step;
      end
   end

   // HI/LO: written on the DONE edge or by MTHI/MTLO in IDLE, held otherwise.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hi <= '0;
         lo <= '0;
      end else if (state == S_DONE) begin
         if (!is_div) begin
            {hi, lo} <= prod_fix;
         end else if (div0) begin
            hi <= a_raw;
            lo <= '1;
         end else if (ovf) begin
            hi <= '0;
            lo <= {1'b1, {(WIDTH-1){1'b0}}};
         end else begin
            hi <= rem_fix;
            lo <= quo_fix;
         end
      end else begin
         if (mt_hi) hi <= readData1;
         if (mt_lo) lo <= readData1;
      end
   end

   // done: one-cycle pulse following the HI/LO write.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) done <= 1'b0;
      else          done <= (state == S_DONE);
   end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Testbench for exe_muldiv_unit.
// Directed cases plus randomized ops against an arithmetic reference model.
// A scoreboard queue of expected {hi,lo} is drained by a done monitor.
module tb_exe_muldiv_unit;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd7;
   logic [31:0] readData1 = '0;
   logic [31:0] readData2 = '0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int          n_chk = 0;
   int          n_pass = 0;
   logic [63:0] sb_q[$];
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   exe_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .op(op),
      .readData1(readData1), .readData2(readData2),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clock = ~clock;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endfunction

   function automatic int exp_len(logic [2:0] o);
`ifdef MULDIV_FAST_MUL_EN
      if (o <= 3'd1) return 1;
`endif
      return 33;
   endfunction

   // Reference model: plain signed/unsigned arithmetic with the two special cases.
   task automatic model(input logic [2:0] o, input logic [31:0] a, b,
                        output logic [31:0] eh, output logic [31:0] el);
      longint      sp;
      logic [63:0] up;
      int          sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      eh = m_hi;
      el = m_lo;
      case (o)
         3'd0: begin sp = longint'(sa) * longint'(sb); {eh, el} = sp; end
         3'd1: begin up = {32'd0, a} * {32'd0, b}; {eh, el} = up; end
         3'd2: begin
            if (b == 0) begin eh = a; el = 32'hFFFF_FFFF; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               eh = 32'd0; el = 32'h8000_0000;
            end else begin el = sa / sb; eh = sa % sb; end
         end
         3'd3: begin
            if (b == 0) begin eh = a; el = 32'hFFFF_FFFF; end
            else begin el = a / b; eh = a % b; end
         end
         default: ;
      endcase
   endtask

   // Drive one request for one edge; MT/no-op results are checked right after that edge.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, b);
      logic [31:0] eh, el;
      @(negedge clock);
      start = 1'b1; op = o; readData1 = a; readData2 = b;
      if (o <= 3'd3) begin
         model(o, a, b, eh, el);
         sb_q.push_back({eh, el});
         m_hi = eh;
         m_lo = el;
      end else if (o == 3'd4) m_hi = a;
      else if (o == 3'd5) m_lo = a;
      @(posedge clock);
      #1;
      start = 1'b0; op = 3'd7;
      if (o > 3'd3) begin
         chk("mt_busy", 64'(busy), 64'(0));
         chk("mt_hi", 64'(hi), 64'(m_hi));
         chk("mt_lo", 64'(lo), 64'(m_lo));
      end
   endtask

   // Count remaining busy cycles, bounded.
   task automatic wait_busy(input int exp);
      int n = 0;
      @(negedge clock);
      while (busy && n < 200) begin
         n++;
         @(negedge clock);
      end
      chk("busy_len", 64'(n), 64'(exp));
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] a, b);
      issue(o, a, b);
      if (o <= 3'd3) wait_busy(exp_len(o));
   endtask

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Scoreboard monitor: every done pulse must match the oldest pending result.
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clock);
         if (reset_n && done) begin
            if (sb_q.size() == 0) chk("done_without_op", 64'(done), 64'(0));
            else begin
               e = sb_q.pop_front();
               chk("hi", 64'(hi), 64'(e[63:32]));
               chk("lo", 64'(lo), 64'(e[31:0]));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] ph, pl;
      logic [2:0]  o;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_hi", 64'(hi), 64'(0));
      chk("rst_lo", 64'(lo), 64'(0));
      @(negedge clock);
      reset_n = 1'b1;

      // Directed cases.
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(3'd0, 32'hFFFF_FFFD, 32'd5);
      run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
      run_op(3'd3, 32'd100, 32'd0);
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(3'd2, 32'hFFFF_FFF9, 32'd0);
      issue(3'd4, 32'h1234_5678, 32'd0);
      issue(3'd5, 32'h9ABC_DEF0, 32'd0);

      // Requests during BUSY are ignored, including MTHI.
      ph = m_hi;
      pl = m_lo;
      issue(3'd3, 32'd1000, 32'd7);
      repeat (10) @(posedge clock);
      #1;
      start = 1'b1; op = 3'd0; readData1 = 32'd3; readData2 = 32'd4;
      @(posedge clock);
      #1;
      op = 3'd4; readData1 = 32'hDEAD_BEEF;
      @(posedge clock);
      #1;
      start = 1'b0; op = 3'd7;
      chk("ign_busy", 64'(busy), 64'(1));
      chk("ign_hi_hold", 64'(hi), 64'(ph));
      chk("ign_lo_hold", 64'(lo), 64'(pl));
      wait_busy(21);

      // Reset in the middle of a MULT abandons it.
      issue(3'd0, 32'h1234_5678, 32'h0000_0F0F);
      repeat (14) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      chk("mrst_busy", 64'(busy), 64'(0));
      chk("mrst_done", 64'(done), 64'(0));
      chk("mrst_hi", 64'(hi), 64'(0));
      chk("mrst_lo", 64'(lo), 64'(0));
      sb_q.delete();
      m_hi = '0;
      m_lo = '0;
      @(negedge clock);
      reset_n = 1'b1;
      run_op(3'd3, 32'd9, 32'd3);

      // Randomized ops against the model.
      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 7));
         run_op(o, rnd_opnd(), rnd_opnd());
      end

      repeat (5) @(negedge clock);
      chk("sb_empty", 64'(sb_q.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
